hdmi_mode_sequencer: RTL and testbench
======================================

Name: hdmi_mode_sequencer

Overview:
Sequences bring-up and re-synchronisation of the HDMI output path. It supervises the HDMI PLL (reset pulse, lock wait, timeout and retry), debounces the video mode reported by the analyser across frames, and holds the HDMI encoder in reset until the PLL is locked and a frame boundary is reached. It runs on the 32 MHz core clock, sits between video_analyzer and the pll/hdmi instances, and replaces direct wiring of hdmi_pll_reset and vreset.

Parameters:
PLL_RST_CYCLES, 64, width of the hdmi_pll_reset pulse in clk cycles (>=2)
LOCK_TIMEOUT, 1048576, clk cycles allowed in WAIT_LOCK before a retry
SETTLE_CYCLES, 4096, clk cycles the lock must be held continuously before use
STABLE_FRAMES, 2, consecutive identical vmode samples required to accept a mode (1..15)
MAX_RETRY, 15, saturating retry count at which error is raised (<=15)

Ports:
clk  in  1  32 MHz core clock
reset  in  1  synchronous, active-high
vs_in_n  in  1  vsync from core, active low, synchronous to clk
vmode_in  in  2  mode from analyser (0 PAL, 1 NTSC, 2 mono, 3 invalid)
pll_lock  in  1  HDMI PLL lock, asynchronous; synchronised internally
hdmi_pll_reset  out  1  reset to HDMI PLL, active high
hdmi_reset  out  1  reset/sync to HDMI encoder, active high
active_mode  out  2  debounced mode driven to encoder
running  out  1  high only in RUN
retry_count  out  4  number of lock timeouts since reset, saturating
error  out  1  sticky; set when retry_count reaches MAX_RETRY

Behaviour:
- Reset values: hdmi_pll_reset=1, hdmi_reset=1, active_mode=0, running=0, retry_count=0, error=0; state=PLL_RST with counter cleared; candidate=0, stable count=0.
- pll_lock passes through a two-flop synchroniser; lock_s lags the input by 2 cycles. All decisions use lock_s.
- Frame tick: one-cycle pulse on the falling edge of vs_in_n (registered previous value, 1 cycle latency).
- Mode debounce, every frame tick in all states: vmode_in==3 clears stable count. Otherwise, if vmode_in equals candidate, stable count increments (saturating at 15); if not, candidate<=vmode_in and stable count<=1. A mode is accepted when stable count>=STABLE_FRAMES and candidate!=active_mode.
- States:
  PLL_RST: hdmi_pll_reset=1, hdmi_reset=1. Counts PLL_RST_CYCLES, then goes to WAIT_LOCK with counter cleared.
  WAIT_LOCK: hdmi_pll_reset=0, hdmi_reset=1. lock_s=1 -> SETTLE, counter cleared. Counter reaches LOCK_TIMEOUT-1 -> PLL_RST, retry_count+1 saturating at 15, error set when the new value >= MAX_RETRY. Retries continue after error.
  SETTLE: hdmi_reset=1. lock_s=0 -> WAIT_LOCK, counter cleared. Counter reaches SETTLE_CYCLES-1 -> WAIT_FRAME.
  WAIT_FRAME: hdmi_reset=1. lock_s=0 -> WAIT_LOCK. On a frame tick: active_mode<=candidate if stable count>=STABLE_FRAMES (otherwise unchanged), then -> RUN.
  RUN: hdmi_reset=0, running=1. lock_s=0 -> WAIT_LOCK; hdmi_reset=1 on the next cycle and the PLL is not reset. Accepted mode change -> WAIT_FRAME; the mode is latched at the next frame tick, so hdmi_reset is high for at least one full frame.
- Simultaneous events: lock loss takes priority over mode change. A frame tick coinciding with the settle-counter expiry is ignored; WAIT_FRAME needs a later tick.
- hdmi_reset and running are registered and change on the cycle after the state transition.
- Synchronous reset mid-sequence returns to PLL_RST immediately; retry_count and error clear.

Decomposition:
- Package hdmi_seq_pkg: state enum (PLL_RST, WAIT_LOCK, SETTLE, WAIT_FRAME, RUN), mode constants (MODE_PAL=0, MODE_NTSC=1, MODE_MONO=2, MODE_INVALID=3).
- One sub-module, sync_2ff (parameter width), for pll_lock. The counter and debounce logic stay inline.

Test Plan (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8, STABLE_FRAMES=2, MAX_RETRY=3):
- Lock rises 10 cycles after reset release, vmode_in=1 held, vsync every 200 cycles -> hdmi_pll_reset is low after 4 cycles; running rises at the second frame tick after settle; active_mode=1.
- pll_lock stays 0 -> hdmi_pll_reset re-pulses every 36 cycles; retry_count steps 1,2,3,4; error rises with retry_count=3 and stays high.
- In RUN, pll_lock drops for 3 cycles -> hdmi_reset=1 within 4 cycles; hdmi_pll_reset stays 0; running returns after SETTLE plus the next frame tick.
- In RUN, vmode_in 1->2 for one frame then back to 1 -> no effect. 1->2 held for 2 frames -> running=0, hdmi_reset high one frame, active_mode=2, RUN resumes.
- vmode_in=3 for 5 frames in RUN -> active_mode unchanged, running stays 1.
- reset asserted during SETTLE -> next cycle hdmi_pll_reset=1, hdmi_reset=1, retry_count=0, error=0.

Source files
------------

// File: rtl/hdmi_seq_pkg.sv
// Shared types for the HDMI output bring-up sequencer.
// State encoding and analyser mode codes.
package hdmi_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        SETTLE,
        WAIT_FRAME,
        RUN
    } state_t;

    localparam logic [1:0] MODE_PAL     = 2'd0;
    localparam logic [1:0] MODE_NTSC    = 2'd1;
    localparam logic [1:0] MODE_MONO    = 2'd2;
    localparam logic [1:0] MODE_INVALID = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Output lags the input by two clk cycles.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdmi_mode_sequencer.sv
// HDMI PLL supervision, video mode debounce and encoder reset sequencing.
// Encoder leaves reset only with a settled lock, on a frame boundary.
module hdmi_mode_sequencer #(
    parameter int PLL_RST_CYCLES = 64,
    parameter int LOCK_TIMEOUT   = 1048576,
    parameter int SETTLE_CYCLES  = 4096,
    parameter int STABLE_FRAMES  = 2,
    parameter int MAX_RETRY      = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vs_in_n,
    input  logic [1:0] vmode_in,
    input  logic       pll_lock,
    output logic       hdmi_pll_reset,
    output logic       hdmi_reset,
    output logic [1:0] active_mode,
    output logic       running,
    output logic [3:0] retry_count,
    output logic       error
);

    import hdmi_seq_pkg::*;

    localparam int CNT_MAX =
        (LOCK_TIMEOUT > SETTLE_CYCLES) ?
        ((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES) :
        ((SETTLE_CYCLES > PLL_RST_CYCLES) ? SETTLE_CYCLES : PLL_RST_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    STABLE_MIN  = 4'(STABLE_FRAMES);
    localparam logic [3:0]    RETRY_LIM   = 4'(MAX_RETRY);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lock_s;
    logic          vs_prev;
    logic          frame_tick;
    logic [1:0]    candidate;
    logic [3:0]    stable_cnt;
    logic          stable_ok;
    logic          accept;
    logic [3:0]    retry_next;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (clk),
        .reset(reset),
        .d    (pll_lock),
        .q    (lock_s)
    );

    assign frame_tick = vs_prev & ~vs_in_n;
    assign stable_ok  = (stable_cnt >= STABLE_MIN);
    assign accept     = stable_ok && (candidate != active_mode);
    assign retry_next = (retry_count == 4'hf) ? 4'hf : retry_count + 4'd1;

    // Debounce runs in every state so a mode is ready when lock settles.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_prev    <= 1'b1;
            candidate  <= MODE_PAL;
            stable_cnt <= 4'd0;
        end else begin
            vs_prev <= vs_in_n;
            if (frame_tick) begin
                if (vmode_in == MODE_INVALID) begin
                    stable_cnt <= 4'd0;
                end else if (vmode_in == candidate) begin
                    if (stable_cnt != 4'hf)
                        stable_cnt <= stable_cnt + 4'd1;
                end else begin
                    candidate  <= vmode_in;
                    stable_cnt <= 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= PLL_RST;
            cnt            <= '0;
            hdmi_pll_reset <= 1'b1;
            hdmi_reset     <= 1'b1;
            active_mode    <= MODE_PAL;
            running        <= 1'b0;
            retry_count    <= 4'd0;
            error          <= 1'b0;
        end else begin
            hdmi_reset <= (state != RUN);
            running    <= (state == RUN);
            cnt        <= cnt + 1'b1;
            unique case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state          <= WAIT_LOCK;
                        cnt            <= '0;
                        hdmi_pll_reset <= 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state          <= PLL_RST;
                        cnt            <= '0;
                        hdmi_pll_reset <= 1'b1;
                        retry_count    <= retry_next;
                        if (retry_next >= RETRY_LIM)
                            error <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        state <= WAIT_FRAME;
                        cnt   <= '0;
                    end
                end
                WAIT_FRAME: begin
                    cnt <= '0;
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (frame_tick) begin
                        if (stable_ok)
                            active_mode <= candidate;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= '0;
                    // Lock loss outranks a pending mode change.
                    if (!lock_s)
                        state <= WAIT_LOCK;
                    else if (accept)
                        state <= WAIT_FRAME;
                end
                default: begin
                    state <= PLL_RST;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Directed bench for hdmi_mode_sequencer with shortened timing parameters.
// Free-running vsync, period 200 clk cycles, low for 10.
module tb_hdmi_mode_sequencer;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int SETTLE_CYCLES  = 8;
    localparam int STABLE_FRAMES  = 2;
    localparam int MAX_RETRY      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vs_in_n = 1'b1;
    logic [1:0] vmode_in = 2'd1;
    logic       pll_lock = 1'b0;
    logic       hdmi_pll_reset;
    logic       hdmi_reset;
    logic [1:0] active_mode;
    logic       running;
    logic [3:0] retry_count;
    logic       error;

    int compared = 0;
    int mismatched = 0;
    int vphase = 199;
    logic pll_hi_seen;
    logic run_drop;

    hdmi_mode_sequencer #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .STABLE_FRAMES (STABLE_FRAMES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vs_in_n       (vs_in_n),
        .vmode_in      (vmode_in),
        .pll_lock      (pll_lock),
        .hdmi_pll_reset(hdmi_pll_reset),
        .hdmi_reset    (hdmi_reset),
        .active_mode   (active_mode),
        .running       (running),
        .retry_count   (retry_count),
        .error         (error)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            vphase  = (vphase == 199) ? 0 : vphase + 1;
            vs_in_n = (vphase >= 10);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (hdmi_pll_reset) pll_hi_seen = 1'b1;
            if (!running) run_drop = 1'b1;
        end
    endtask

    task automatic wait_tick();
        int budget;
        budget = 0;
        do begin
            step();
            budget++;
        end while (vphase != 0 && budget < 250);
        check("vsync_wait", 32'(budget < 250), 32'd1);
    endtask

    task automatic wait_running(input string tag, input logic [1:0] mode,
                                input int budget);
        int n;
        n = 0;
        while (!(running && active_mode == mode) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_running"}, 32'(running), 32'd1);
        check({tag, "_mode"}, 32'(active_mode), 32'(mode));
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_pll_reset", 32'(hdmi_pll_reset), 32'd1);
        check("rst_hdmi_reset", 32'(hdmi_reset), 32'd1);
        check("rst_active_mode", 32'(active_mode), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        // Bring-up: lock 10 cycles after release, NTSC held
        reset = 1'b0;
        step(3);
        check("up_pll_reset_hi", 32'(hdmi_pll_reset), 32'd1);
        step(2);
        check("up_pll_reset_lo", 32'(hdmi_pll_reset), 32'd0);
        step(5);
        pll_lock = 1'b1;
        wait_running("up", 2'd1, 1500);
        check("up_hdmi_reset", 32'(hdmi_reset), 32'd0);

        // Short lock drop in RUN
        pll_hi_seen = 1'b0;
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        step(1);
        check("drop_hdmi_reset", 32'(hdmi_reset), 32'd1);
        check("drop_running", 32'(running), 32'd0);
        wait_running("drop", 2'd1, 600);
        check("drop_no_pll_reset", 32'(pll_hi_seen), 32'd0);
        check("drop_retry", 32'(retry_count), 32'd0);

        // One-frame glitch to mono is ignored
        wait_tick();
        run_drop = 1'b0;
        step(5);
        vmode_in = 2'd2;
        wait_tick();
        step(5);
        vmode_in = 2'd1;
        wait_tick();
        wait_tick();
        step(5);
        check("glitch_no_drop", 32'(run_drop), 32'd0);
        check("glitch_mode", 32'(active_mode), 32'd1);

        // Mono held two frames switches mode via one frame of reset
        vmode_in = 2'd2;
        wait_tick();
        wait_tick();
        step(5);
        check("switch_running", 32'(running), 32'd0);
        check("switch_hdmi_reset", 32'(hdmi_reset), 32'd1);
        check("switch_mode_old", 32'(active_mode), 32'd1);
        wait_tick();
        step(5);
        check("switch_running_back", 32'(running), 32'd1);
        check("switch_mode_new", 32'(active_mode), 32'd2);
        check("switch_hdmi_reset_lo", 32'(hdmi_reset), 32'd0);

        // Invalid mode for five frames leaves RUN alone
        run_drop = 1'b0;
        vmode_in = 2'd3;
        for (int f = 0; f < 5; f++) wait_tick();
        step(5);
        check("invalid_no_drop", 32'(run_drop), 32'd0);
        check("invalid_mode", 32'(active_mode), 32'd2);
        vmode_in = 2'd2;

        // No lock: retry every 36 cycles, error at 3
        reset = 1'b1;
        pll_lock = 1'b0;
        step(1);
        reset = 1'b0;
        step(35);
        check("retry0", 32'(retry_count), 32'd0);
        check("retry0_pll_lo", 32'(hdmi_pll_reset), 32'd0);
        step(1);
        check("retry1", 32'(retry_count), 32'd1);
        check("retry1_pll_hi", 32'(hdmi_pll_reset), 32'd1);
        step(3);
        check("retry1_pll_hi_end", 32'(hdmi_pll_reset), 32'd1);
        step(1);
        check("retry1_pll_lo", 32'(hdmi_pll_reset), 32'd0);
        step(32);
        check("retry2", 32'(retry_count), 32'd2);
        check("retry2_error", 32'(error), 32'd0);
        step(36);
        check("retry3", 32'(retry_count), 32'd3);
        check("retry3_error", 32'(error), 32'd1);
        step(36);
        check("retry4", 32'(retry_count), 32'd4);
        check("retry4_error", 32'(error), 32'd1);

        // Lock now arrives; reset while in SETTLE
        pll_lock = 1'b1;
        step(8);
        check("settle_retry_kept", 32'(retry_count), 32'd4);
        check("settle_hdmi_reset", 32'(hdmi_reset), 32'd1);
        reset = 1'b1;
        step(1);
        check("mid_rst_pll_reset", 32'(hdmi_pll_reset), 32'd1);
        check("mid_rst_hdmi_reset", 32'(hdmi_reset), 32'd1);
        check("mid_rst_retry", 32'(retry_count), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_running", 32'(running), 32'd0);
        reset = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
